// File: rtl/cic_dec_ctrl.sv
// cic_dec_ctrl -- sequencing controller for a multi-stage CIC decimator.
//
// Runs the integrator and comb register banks from the same clock by using
// enables instead of a divided comb clock. It produces the integrator advance,
// the decimation strobe (comb advance) and the comb-output valid. It also
// clears the pipeline on every start and takes run-time ratio/shift
// configuration, which is only applied on decimation boundaries.
//
// Ports
//   clk, reset    : clock; synchronous active-high reset
//   enable        : run request (1 = run, 0 = stop)
//   in_valid      : an ADC sample is present this cycle
//   cfg_valid     : configuration offered
//   cfg_ready     : configuration accepted when high together with cfg_valid
//   cfg_rate      : requested decimation ratio (values below 2 are clamped to 2)
//   cfg_shift     : requested output shift select
//   cfg_err       : one-cycle pulse after a capture whose rate was clamped
//   pipe_clr      : one-cycle clear of the integrator/comb registers
//   int_en        : integrator advance, one cycle after an accepted sample
//   dec_strobe    : comb advance, once per rate_cur accepted samples
//   out_valid     : comb result valid, COMB_LAT cycles after a settled strobe
//   shift_sel     : active output shift
//   rate_cur      : active decimation ratio
//   busy          : controller is not IDLE
//   dbg_state     : current FSM state (IDLE=0, CLEAR=1, RUN=2)
//
// Configuration handshake: a transfer happens on a cycle where cfg_valid and
// cfg_ready are both high. cfg_ready is high exactly when no configuration is
// pending. cfg_valid may be raised or dropped at any time and the data is only
// sampled on the transfer cycle.
module cic_dec_ctrl #(
  parameter int RATE_W   = 8,
  parameter int DEF_RATE = 8,
  parameter int STAGES   = 3,
  parameter int COMB_LAT = 3,
  parameter int SHIFT_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [RATE_W-1:0]  cfg_rate,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               cfg_err,
  output logic               pipe_clr,
  output logic               int_en,
  output logic               dec_strobe,
  output logic               out_valid,
  output logic [SHIFT_W-1:0] shift_sel,
  output logic [RATE_W-1:0]  rate_cur,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int SETTLE_W = (STAGES < 1) ? 1 : $clog2(STAGES + 1);

  localparam logic [RATE_W-1:0]   RATE_ONE    = RATE_W'(1);
  localparam logic [RATE_W-1:0]   RATE_TWO    = RATE_W'(2);
  localparam logic [RATE_W-1:0]   RATE_DEF    = RATE_W'(DEF_RATE);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(STAGES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RATE_W-1:0]   r_phase;
  logic [SETTLE_W-1:0] r_settle;
  logic [RATE_W-1:0]   r_rate_cur;
  logic [SHIFT_W-1:0]  r_shift_sel;
  logic                r_pend_valid;
  logic [RATE_W-1:0]   r_pend_rate;
  logic [SHIFT_W-1:0]  r_pend_shift;
  logic                r_cfg_ready;
  logic                r_cfg_err;
  logic                r_pipe_clr;
  logic                r_int_en;
  logic                r_dec_strobe;
  logic                r_busy;
  // Bit 0 is loaded together with dec_strobe; bit COMB_LAT drives out_valid.
  logic [COMB_LAT:0]   r_ov_pipe;

  logic                w_active;
  logic                w_accept;
  logic                w_boundary;
  logic                w_capture;
  logic                w_apply;
  logic                w_flush;
  logic                w_tag;
  logic [RATE_W-1:0]   w_rate_m1;
  logic [RATE_W-1:0]   w_cap_rate;
  logic [RATE_W-1:0]   w_phase_nxt;
  logic [SETTLE_W-1:0] w_settle_nxt;

  // Samples are counted in CLEAR as well as RUN. The phase is zeroed on entry
  // to CLEAR, so the first strobe lands exactly rate_cur cycles after the
  // clear cycle when in_valid is held high.
  assign w_active   = (r_state != IDLE);
  assign w_accept   = w_active && in_valid;
  assign w_rate_m1  = r_rate_cur - RATE_ONE;
  assign w_boundary = (r_state == RUN) && in_valid && (r_phase == w_rate_m1);
  assign w_capture  = cfg_valid && r_cfg_ready;
  assign w_cap_rate = (cfg_rate < RATE_TWO) ? RATE_TWO : cfg_rate;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_apply      = 1'b0;
    w_flush      = 1'b0;
    w_tag        = 1'b0;
    w_phase_nxt  = '0;
    w_settle_nxt = r_settle;

    unique case (r_state)
      IDLE: begin
        // A pending configuration lands the cycle after it was captured.
        w_apply = r_pend_valid;
        if (enable) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_state_nxt = enable ? RUN : IDLE;
      end
      RUN: begin
        // Stop wins over a boundary; the pending config then waits for IDLE.
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_boundary && r_pend_valid) begin
          w_state_nxt = CLEAR;
          w_apply     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Leaving RUN/CLEAR for anything but RUN kills every in-flight comb
    // result, including the one belonging to a strobe issued on this edge.
    w_flush = w_active && (w_state_nxt != RUN);
    w_tag   = w_boundary && (r_settle == '0) && !w_flush;

    if (w_active && (w_state_nxt == RUN)) begin
      if (w_accept) begin
        w_phase_nxt = w_boundary ? '0 : (r_phase + RATE_ONE);
      end else begin
        w_phase_nxt = r_phase;
      end
    end

    if (w_state_nxt == CLEAR) begin
      w_settle_nxt = SETTLE_INIT;
    end else if (w_boundary && (r_settle != '0)) begin
      w_settle_nxt = r_settle - SETTLE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase      <= '0;
      r_settle     <= '0;
      r_rate_cur   <= RATE_DEF;
      r_shift_sel  <= '0;
      r_pend_valid <= 1'b0;
      r_pend_rate  <= RATE_DEF;
      r_pend_shift <= '0;
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
      r_pipe_clr   <= 1'b0;
      r_int_en     <= 1'b0;
      r_dec_strobe <= 1'b0;
      r_busy       <= 1'b0;
      r_ov_pipe    <= '0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_settle     <= w_settle_nxt;
      r_pipe_clr   <= (w_state_nxt == CLEAR);
      r_int_en     <= w_accept;
      r_dec_strobe <= w_boundary;
      r_busy       <= (w_state_nxt != IDLE);
      r_cfg_err    <= w_capture && (cfg_rate < RATE_TWO);
      r_ov_pipe    <= w_flush ? '0 : {r_ov_pipe[COMB_LAT-1:0], w_tag};

      // Capture needs an empty pending slot and apply needs a full one, so
      // the two never happen on the same cycle.
      if (w_capture) begin
        r_pend_valid <= 1'b1;
        r_pend_rate  <= w_cap_rate;
        r_pend_shift <= cfg_shift;
        r_cfg_ready  <= 1'b0;
      end else if (w_apply) begin
        r_pend_valid <= 1'b0;
        r_cfg_ready  <= 1'b1;
        r_rate_cur   <= r_pend_rate;
        r_shift_sel  <= r_pend_shift;
      end
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign cfg_err    = r_cfg_err;
  assign pipe_clr   = r_pipe_clr;
  assign int_en     = r_int_en;
  assign dec_strobe = r_dec_strobe;
  assign out_valid  = r_ov_pipe[COMB_LAT];
  assign shift_sel  = r_shift_sel;
  assign rate_cur   = r_rate_cur;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb_cic_dec_ctrl -- directed self-checking bench for cic_dec_ctrl.
// Expected dec_strobe / out_valid cycle numbers are queued when a run is
// started and are popped by a negedge monitor whenever the DUT raises them.
module tb_cic_dec_ctrl;

  localparam int RATE_W  = 8;
  localparam int SHIFT_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               in_valid;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [RATE_W-1:0]  cfg_rate;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               cfg_err;
  logic               pipe_clr;
  logic               int_en;
  logic               dec_strobe;
  logic               out_valid;
  logic [SHIFT_W-1:0] shift_sel;
  logic [RATE_W-1:0]  rate_cur;
  logic               busy;
  logic [1:0]         dbg_state;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_strb_q[$];
  logic [31:0] exp_ov_q[$];

  cic_dec_ctrl #(
    .RATE_W   (RATE_W),
    .DEF_RATE (8),
    .STAGES   (3),
    .COMB_LAT (3),
    .SHIFT_W  (SHIFT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_rate   (cfg_rate),
    .cfg_shift  (cfg_shift),
    .cfg_err    (cfg_err),
    .pipe_clr   (pipe_clr),
    .int_en     (int_en),
    .dec_strobe (dec_strobe),
    .out_valid  (out_valid),
    .shift_sel  (shift_sel),
    .rate_cur   (rate_cur),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout at cycle %0d, required end of test", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_rate_cur"},   rate_cur,   8);
    chk({pfx, "_shift_sel"},  shift_sel,  0);
    chk({pfx, "_cfg_ready"},  cfg_ready,  1);
    chk({pfx, "_cfg_err"},    cfg_err,    0);
    chk({pfx, "_pipe_clr"},   pipe_clr,   0);
    chk({pfx, "_int_en"},     int_en,     0);
    chk({pfx, "_dec_strobe"}, dec_strobe, 0);
    chk({pfx, "_out_valid"},  out_valid,  0);
    chk({pfx, "_busy"},       busy,       0);
    chk({pfx, "_dbg_state"},  dbg_state,  0);
  endtask

  task automatic check_queues_empty(input string pfx);
    chk({pfx, "_strobe_q_left"}, exp_strb_q.size(), 0);
    chk({pfx, "_ov_q_left"},     exp_ov_q.size(),   0);
  endtask

  // Scoreboard monitor: every strobe / out_valid must match the queue head.
  always @(negedge clk) begin
    if (dec_strobe) begin
      if (exp_strb_q.size() > 0) chk("strobe_cycle", cyc, exp_strb_q.pop_front());
      else                       chk("strobe_unexpected", cyc, 32'hFFFF_FFFF);
    end
    if (out_valid) begin
      if (exp_ov_q.size() > 0) chk("out_valid_cycle", cyc, exp_ov_q.pop_front());
      else                     chk("out_valid_unexpected", cyc, 32'hFFFF_FFFF);
    end
  end

  initial begin
    int c;
    int cp;
    int c2;
    int c3;
    int c4;
    int g;
    logic [SHIFT_W-1:0] sh;

    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cfg_rate  = '0;
    cfg_shift = '0;
    repeat (3) tick();
    check_reset_values("reset");

    // IDLE ignores samples.
    reset    = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    chk("idle_int_en", int_en, 0);
    chk("idle_busy", busy, 0);

    // Rate 8, in_valid toggling 1,0: strobes every 16 cycles, int_en follows
    // in_valid by one cycle. Stop one cycle after the 4th strobe, whose
    // out_valid must never appear.
    enable = 1'b1;
    c2 = cyc + 1;
    for (int j = 0; j < 4; j++) exp_strb_q.push_back(c2 + 15 + 16 * j);
    tick();
    while (cyc <= c2 + 64) begin
      in_valid = ((cyc - c2) % 2 == 0);
      enable   = (cyc < c2 + 64);
      if (cyc == c2) begin
        chk("tog_pipe_clr", pipe_clr, 1);
        chk("tog_int_en_from_idle", int_en, 0);
        chk("tog_dbg_clear", dbg_state, 1);
      end
      if (cyc == c2 + 1) begin
        chk("tog_pipe_clr_one_cycle", pipe_clr, 0);
        chk("tog_dbg_run", dbg_state, 2);
      end
      if (cyc > c2 && cyc <= c2 + 8) chk("tog_int_en", int_en, ((cyc - c2 - 1) % 2 == 0));
      if (cyc == c2 + 64) chk("tog_busy_before_stop", busy, 1);
      tick();
    end
    in_valid = 1'b0;
    chk("tog_busy_after_stop", busy, 0);
    repeat (12) tick();
    check_queues_empty("tog");

    // Rate 8, in_valid constant: strobes every 8, first three discarded,
    // out_valid 3 cycles after the 4th. A rate-5 config offered mid-frame is
    // applied on the next boundary with a re-clear; then stop after a strobe.
    sh       = SHIFT_W'($urandom_range(1, 31));
    enable   = 1'b1;
    in_valid = 1'b1;
    c  = cyc + 1;
    cp = c + 56;
    for (int k = 1; k <= 7; k++) exp_strb_q.push_back(c + 8 * k);
    exp_ov_q.push_back(c + 35);
    exp_ov_q.push_back(c + 43);
    exp_ov_q.push_back(c + 51);
    for (int k = 1; k <= 5; k++) exp_strb_q.push_back(cp + 5 * k);
    exp_ov_q.push_back(cp + 23);
    tick();
    while (cyc <= cp + 26) begin
      enable    = (cyc < cp + 26);
      cfg_valid = (cyc == c + 50);
      cfg_rate  = 8'd5;
      cfg_shift = sh;
      if (cyc == c)      chk("run_pipe_clr", pipe_clr, 1);
      if (cyc == c + 1)  chk("run_pipe_clr_one_cycle", pipe_clr, 0);
      if (cyc == c + 50) chk("run_cfg_ready_offer", cfg_ready, 1);
      if (cyc == c + 51) chk("run_cfg_ready_pending", cfg_ready, 0);
      if (cyc == c + 55) begin
        chk("run_cfg_ready_until_boundary", cfg_ready, 0);
        chk("run_rate_before_apply", rate_cur, 8);
        chk("run_shift_before_apply", shift_sel, 0);
      end
      if (cyc == cp) begin
        chk("run_cfg_ready_after_apply", cfg_ready, 1);
        chk("run_rate_applied", rate_cur, 5);
        chk("run_shift_applied", shift_sel, sh);
        chk("run_reclear", pipe_clr, 1);
      end
      if (cyc == cp + 1)  chk("run_reclear_one_cycle", pipe_clr, 0);
      if (cyc == cp + 26) chk("run_busy_before_stop", busy, 1);
      tick();
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    chk("run_busy_after_stop", busy, 0);
    repeat (12) tick();
    check_queues_empty("run");

    // IDLE config rate 4 / shift 6 lands two cycles after the offer. Run at
    // period 4; a config captured on a boundary waits for the next one.
    cfg_valid = 1'b1;
    cfg_rate  = 8'd4;
    cfg_shift = 5'd6;
    chk("idlecfg_ready_offer", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    chk("idlecfg_ready_low", cfg_ready, 0);
    chk("idlecfg_rate_not_yet", rate_cur, 5);
    chk("idlecfg_no_err", cfg_err, 0);
    tick();
    chk("idlecfg_rate", rate_cur, 4);
    chk("idlecfg_shift", shift_sel, 6);
    chk("idlecfg_ready_back", cfg_ready, 1);
    enable   = 1'b1;
    in_valid = 1'b1;
    c3 = cyc + 1;
    c4 = c3 + 16;
    for (int k = 1; k <= 4; k++) exp_strb_q.push_back(c3 + 4 * k);
    for (int k = 1; k <= 4; k++) exp_strb_q.push_back(c4 + 6 * k);
    tick();
    while (cyc <= c4 + 25) begin
      enable    = (cyc < c4 + 25);
      cfg_valid = (cyc == c3 + 11);
      cfg_rate  = 8'd6;
      cfg_shift = 5'd1;
      if (cyc == c3 + 12) begin
        chk("bnd_cap_rate_held", rate_cur, 4);
        chk("bnd_cap_no_clear", pipe_clr, 0);
        chk("bnd_cap_ready_low", cfg_ready, 0);
      end
      if (cyc == c4) begin
        chk("bnd_next_rate", rate_cur, 6);
        chk("bnd_next_shift", shift_sel, 1);
        chk("bnd_next_clear", pipe_clr, 1);
      end
      tick();
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    chk("bnd_busy_after_stop", busy, 0);
    repeat (12) tick();
    check_queues_empty("bnd");

    // Rate 1 requested: clamped to 2 with a one-cycle cfg_err.
    sh        = SHIFT_W'($urandom_range(8, 31));
    cfg_valid = 1'b1;
    cfg_rate  = 8'd1;
    cfg_shift = sh;
    tick();
    cfg_valid = 1'b0;
    chk("clamp_err_pulse", cfg_err, 1);
    chk("clamp_ready_low", cfg_ready, 0);
    tick();
    chk("clamp_err_one_cycle", cfg_err, 0);
    chk("clamp_rate", rate_cur, 2);
    chk("clamp_shift", shift_sel, sh);

    // Reset in RUN with a config pending: everything back to reset values
    // and the pending config is dropped.
    enable   = 1'b1;
    in_valid = 1'b1;
    g = cyc + 1;
    for (int k = 1; k <= 3; k++) exp_strb_q.push_back(g + 2 * k);
    tick();
    while (cyc <= g + 6) begin
      cfg_valid = (cyc == g + 6);
      cfg_rate  = 8'd9;
      cfg_shift = 5'd4;
      if (cyc == g + 6) chk("rst_cfg_ready_offer", cfg_ready, 1);
      tick();
    end
    cfg_valid = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    chk("rst_pending_before", cfg_ready, 0);
    chk("rst_busy_before", busy, 1);
    tick();
    check_reset_values("rst_mid");
    reset = 1'b0;
    tick();
    tick();
    chk("rst_pending_discarded_rate", rate_cur, 8);
    chk("rst_pending_discarded_ready", cfg_ready, 1);
    chk("rst_idle_busy", busy, 0);
    repeat (4) tick();
    check_queues_empty("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
Sequencing controller for the multi-stage CIC decimator datapath; single clock domain, replaces a separate divided comb clock with enables.
- Generates the integrator enable, the decimation strobe (comb enable) and the comb-output valid.
- Issues a pipeline clear whenever the datapath starts.
- Accepts run-time decimation-ratio and output-shift configuration through a valid/ready handshake, applied only at decimation boundaries.
- Sits between the ADC sample stream and the integrator/comb register banks.

Parameters:
RATE_W, 8, width of decimation ratio
DEF_RATE, 8, ratio after reset (must be >= 2)
STAGES, 3, comb stages; number of initial comb outputs discarded after every clear
COMB_LAT, 3, clk cycles from dec_strobe to comb result valid
SHIFT_W, 5, width of output scaling shift select

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
enable  in  1  run request; high = run, low = stop
in_valid  in  1  input sample present this cycle
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_rate  in  RATE_W  requested decimation ratio
cfg_shift  in  SHIFT_W  requested output shift
cfg_err  out  1  one-cycle pulse: accepted cfg_rate < 2, clamped to 2
pipe_clr  out  1  one-cycle clear of integrator/comb registers
int_en  out  1  integrator advance
dec_strobe  out  1  comb advance, one cycle per RATE accepted samples
out_valid  out  1  comb output valid
shift_sel  out  SHIFT_W  active output shift
rate_cur  out  RATE_W  active ratio
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; rate_cur=DEF_RATE; shift_sel=0; phase=0; settle=0; no pending cfg. cfg_ready=1; all other 1-bit outputs 0.
- All outputs are registered.
- States: IDLE, CLEAR, RUN.
- IDLE:
  - int_en, dec_strobe and out_valid are held 0.
  - enable=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - pipe_clr=1; phase:=0; settle:=STAGES; out_valid delay line flushed.
  - Next state RUN if enable=1, else IDLE.
- RUN:
  - in_valid at cycle t -> int_en=1 at t+1; phase increments.
  - When phase==rate_cur-1 with in_valid: phase:=0 and dec_strobe=1 at t+1 (the boundary).
  - Strobe period: with in_valid constantly high, one dec_strobe every rate_cur cycles, first strobe rate_cur cycles after the CLEAR cycle.
- out_valid:
  - Asserts COMB_LAT cycles after a dec_strobe, only if settle==0 when the strobe issued.
  - Each strobe issued with settle>0 decrements settle and produces no out_valid.
- Configuration handshake:
  - cfg_ready = no pending config.
  - cfg_valid&&cfg_ready captures rate (clamped to >=2, cfg_err pulse next cycle) and shift into the pending register; cfg_ready drops the next cycle.
  - In IDLE, pending is applied to rate_cur/shift_sel the cycle after capture.
  - In RUN, pending is applied on the boundary cycle. Next state is CLEAR (re-clear, phase/settle reset, in-flight out_valid flushed), then RUN. cfg_ready returns 1 the cycle after apply.
  - A capture coinciding with a boundary is not applied until the next boundary.
- enable=0 in RUN or CLEAR:
  - Next cycle IDLE; phase reset; out_valid delay line flushed, so no out_valid after stop.
  - Any pending config is kept and applied in IDLE.
- Simultaneous boundary and enable fall: stop wins. The dec_strobe for that boundary is still issued; its out_valid is suppressed.
- in_valid gaps: phase holds; strobe timing counts accepted samples only.
- reset mid-operation: everything returns to reset values next cycle, including the pending config, which is discarded.

Test Plan:
- Reset, enable=1, in_valid constant, DEF_RATE=8 -> pipe_clr one cycle; dec_strobe every 8 cycles; first 3 strobes give no out_valid; 4th strobe -> out_valid 3 cycles later, then every 8.
- in_valid toggling 1,0 pattern, rate 8 -> dec_strobe every 16 cycles; int_en mirrors in_valid delayed 1.
- In IDLE, cfg rate=4 shift=6 -> rate_cur=4, shift_sel=6 two cycles after offer; run gives strobe period 4.
- In RUN at rate 8, cfg rate=5 offered mid-frame -> cfg_ready low until boundary; pipe_clr after that boundary; settle restarts (3 discarded outputs); new period 5.
- cfg rate=1 -> cfg_err pulse; rate_cur=2.
- enable dropped 1 cycle after a strobe -> busy 0 next cycle; no out_valid ever follows. Separately, reset asserted in RUN with config pending -> rate_cur=DEF_RATE, cfg_ready=1, outputs 0.
